// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared FSM state encoding and default widths for collatz_stats
package collatz_pkg;

    localparam int XW_DEF = 16;
    localparam int SW_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_sat_cnt.sv
// rtl/collatz_sat_cnt.sv - saturating up-counter with load-on-clear, used for step and odd counts
module collatz_sat_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         full
);

    logic [W-1:0] r_q;

    assign q    = r_q;
    assign full = &r_q;

    // clr with inc loads 1 so the first sample of a window can be counted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? W'(1) : '0;
        end else if (inc && !full) begin
            r_q <= r_q + 1'b1;
        end
    end

endmodule

// File: rtl/collatz_stats.sv
// rtl/collatz_stats.sv - per-window Collatz orbit statistics with valid/ready result and watchdog
// Optional odd_cnt output enabled by defining COLLATZ_STATS_ODD_EN.
module collatz_stats
    import collatz_pkg::*;
#(
    parameter int XW  = XW_DEF,
    parameter int SW  = SW_DEF,
    parameter int TMO = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] x_in,
    input  logic          bs_in,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [XW-1:0] start_v,
    output logic [XW-1:0] peak_v,
    output logic [SW-1:0] steps,
    output logic          sat,
    output logic          tmo,
    output logic          ovr
`ifdef COLLATZ_STATS_ODD_EN
    ,
    output logic [SW-1:0] odd_cnt
`endif
);

    localparam int             CW       = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0]  CYC_LAST = CW'((TMO > 0) ? (TMO - 1) : 0);

    state_t         r_state;
    logic           r_bs_q;
    logic [XW-1:0]  r_last;
    logic [CW-1:0]  r_cyc;
    logic           r_vld;
    logic [XW-1:0]  r_start;
    logic [XW-1:0]  r_peak;
    logic           r_sat;
    logic           r_tmo;
    logic           r_ovr;

    logic           w_rise;
    logic           w_enter;
    logic           w_change;
    logic           w_wdog;
    logic           w_steps_full;

    assign w_rise   = bs_in & ~r_bs_q;
    // a new window may start from IDLE, or from DONE when the record is taken on the same edge
    assign w_enter  = w_rise && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && res_rdy));
    assign w_change = (r_state == ST_RUN) && bs_in && (x_in != r_last);
    assign w_wdog   = (TMO != 0) && (r_cyc == CYC_LAST);

    collatz_sat_cnt #(.W(SW)) u_steps (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_enter),
        .inc   (w_change),
        .q     (steps),
        .full  (w_steps_full)
    );

`ifdef COLLATZ_STATS_ODD_EN
    logic w_odd_full;

    collatz_sat_cnt #(.W(SW)) u_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_enter),
        .inc   ((w_enter | (w_change & ~w_odd_full)) & x_in[0]),
        .q     (odd_cnt),
        .full  (w_odd_full)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bs_q  <= 1'b0;
            r_last  <= '0;
            r_cyc   <= '0;
            r_vld   <= 1'b0;
            r_start <= '0;
            r_peak  <= '0;
            r_sat   <= 1'b0;
            r_tmo   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_bs_q <= bs_in;
            if (w_enter) begin
                r_state <= ST_RUN;
                r_start <= x_in;
                r_peak  <= x_in;
                r_last  <= x_in;
                r_cyc   <= '0;
                r_sat   <= 1'b0;
                r_tmo   <= 1'b0;
                r_vld   <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_cyc <= r_cyc + 1'b1;
                        if (w_change) begin
                            r_last <= x_in;
                            if (x_in > r_peak) r_peak <= x_in;
                            if (w_steps_full) r_sat <= 1'b1;
                        end
                        if (!bs_in) begin
                            r_vld   <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_wdog) begin
                            r_tmo   <= 1'b1;
                            r_vld   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (res_rdy) begin
                            r_vld   <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (w_rise) begin
                            r_ovr <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign res_vld = r_vld;
    assign start_v = r_start;
    assign peak_v  = r_peak;
    assign sat     = r_sat;
    assign tmo     = r_tmo;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_collatz_stats.sv
// tb/tb_collatz_stats.sv - directed self-checking bench for collatz_stats
module tb_collatz_stats;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x;
    logic        bs;
    logic        rdy;
    logic        vld;
    logic [15:0] start_v;
    logic [15:0] peak_v;
    logic [9:0]  steps;
    logic        sat;
    logic        tmo;
    logic        ovr;

    logic [15:0] x5;
    logic        bs5;
    logic        rdy5;
    logic        vld5;
    logic [15:0] start5;
    logic [15:0] peak5;
    logic [3:0]  steps5;
    logic        sat5;
    logic        tmo5;
    logic        ovr5;

`ifdef COLLATZ_STATS_ODD_EN
    logic [9:0]  odd_cnt;
    logic [3:0]  odd5;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] orbit_q[$];

    always #5 clk = ~clk;

    collatz_stats dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_in    (x),
        .bs_in   (bs),
        .res_vld (vld),
        .res_rdy (rdy),
        .start_v (start_v),
        .peak_v  (peak_v),
        .steps   (steps),
        .sat     (sat),
        .tmo     (tmo),
        .ovr     (ovr)
`ifdef COLLATZ_STATS_ODD_EN
        ,
        .odd_cnt (odd_cnt)
`endif
    );

    collatz_stats #(.XW(16), .SW(4), .TMO(50)) dut5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_in    (x5),
        .bs_in   (bs5),
        .res_vld (vld5),
        .res_rdy (rdy5),
        .start_v (start5),
        .peak_v  (peak5),
        .steps   (steps5),
        .sat     (sat5),
        .tmo     (tmo5),
        .ovr     (ovr5)
`ifdef COLLATZ_STATS_ODD_EN
        ,
        .odd_cnt (odd5)
`endif
    );

    // drives orbit_q with bs high, each value held for 'hold' clocks; returns at a negedge
    task automatic play(input int hold);
        foreach (orbit_q[i]) begin
            repeat (hold) begin
                x  = orbit_q[i];
                bs = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; x = 16'h1234; bs = 1'b0; rdy = 1'b0;
        x5 = 16'h0; bs5 = 1'b0; rdy5 = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({vld, start_v, peak_v, steps, sat, tmo, ovr} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", {vld, start_v, peak_v, steps, sat, tmo, ovr});
        end
        n_tests++;
        if ({vld5, start5, peak5, steps5, sat5, tmo5, ovr5} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_dut5 got=%h want=0", {vld5, start5, peak5, steps5, sat5, tmo5, ovr5});
        end
`ifdef COLLATZ_STATS_ODD_EN
        n_tests++;
        if (odd_cnt !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_odd got=%0d want=0", odd_cnt);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({vld, start_v, steps} !== 27'd0) begin
            n_fail++;
            $display("FAIL idle_hold got=%h want=0", {vld, start_v, steps});
        end
    endtask

    task automatic test_basic;
        orbit_q = '{16'd6, 16'd3, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
        play(1);
        n_tests++;
        if (vld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_vld_early got=%b want=0", vld);
        end
        bs = 1'b0;
        @(negedge clk);
        n_tests++;
        if (vld !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_vld_latency got=%b want=1", vld);
        end
        n_tests++;
        if ({start_v, peak_v, steps, sat, tmo, ovr} !== {16'd6, 16'd16, 10'd8, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_record got=%0d/%0d/%0d/%b%b%b want=6/16/8/000",
                     start_v, peak_v, steps, sat, tmo, ovr);
        end
`ifdef COLLATZ_STATS_ODD_EN
        n_tests++;
        if (odd_cnt !== 10'd3) begin
            n_fail++;
            $display("FAIL basic_odd got=%0d want=3", odd_cnt);
        end
`endif
    endtask

    task automatic test_backpressure;
        int bad = 0;
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({vld, start_v, peak_v, steps, sat, tmo} !== {1'b1, 16'd6, 16'd16, 10'd8, 2'b00}) bad++;
            if (i == 3) begin bs = 1'b1; x = 16'd7; end
            if (i == 6) bs = 1'b0;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_stable got=%0d unstable cycles want=0", bad);
        end
        n_tests++;
        if (ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ovr got=%b want=1", ovr);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        n_tests++;
        if (vld !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept got=%b want=0", vld);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if ({vld, start_v, steps, ovr} !== {1'b0, 16'd6, 10'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL dropped_window got=%b/%0d/%0d/%b want=0/6/8/1", vld, start_v, steps, ovr);
        end
    endtask

    task automatic test_held;
        orbit_q = '{16'd6, 16'd3, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
        play(3);
        bs = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({vld, start_v, peak_v, steps, sat, tmo} !== {1'b1, 16'd6, 16'd16, 10'd8, 2'b00}) begin
            n_fail++;
            $display("FAIL held_record got=%b/%0d/%0d/%0d/%b%b want=1/6/16/8/00",
                     vld, start_v, peak_v, steps, sat, tmo);
        end
`ifdef COLLATZ_STATS_ODD_EN
        n_tests++;
        if (odd_cnt !== 10'd3) begin
            n_fail++;
            $display("FAIL held_odd got=%0d want=3", odd_cnt);
        end
`endif
    endtask

    task automatic test_accept_on_rise;
        rdy = 1'b1; bs = 1'b1; x = 16'd7;
        @(negedge clk);
        rdy = 1'b0;
        n_tests++;
        if ({vld, start_v, steps} !== {1'b0, 16'd7, 10'd0}) begin
            n_fail++;
            $display("FAIL rise_accept got=%b/%0d/%0d want=0/7/0", vld, start_v, steps);
        end
        orbit_q = '{16'd22, 16'd11, 16'd34, 16'd17, 16'd52, 16'd26, 16'd13, 16'd40,
                   16'd20, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
        play(1);
        bs = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({vld, start_v, peak_v, steps, sat, tmo} !== {1'b1, 16'd7, 16'd52, 10'd16, 2'b00}) begin
            n_fail++;
            $display("FAIL orbit7_record got=%b/%0d/%0d/%0d/%b%b want=1/7/52/16/00",
                     vld, start_v, peak_v, steps, sat, tmo);
        end
`ifdef COLLATZ_STATS_ODD_EN
        n_tests++;
        if (odd_cnt !== 10'd6) begin
            n_fail++;
            $display("FAIL orbit7_odd got=%0d want=6", odd_cnt);
        end
`endif
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic test_watchdog;
        int first = 0;
        int late  = 0;
        x5 = 16'd1; bs5 = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (vld5 && first == 0) first = c;
            if (c > 61 && vld5) late++;
            rdy5 = (c == 60);
            x5 = (x5 == 16'd1) ? 16'd2 : 16'd1;
            if (c == 55) begin
                n_tests++;
                if ({tmo5, sat5, steps5, start5, peak5} !== {1'b1, 1'b1, 4'd15, 16'd1, 16'd2}) begin
                    n_fail++;
                    $display("FAIL wdog_record got=%b%b/%0d/%0d/%0d want=11/15/1/2",
                             tmo5, sat5, steps5, start5, peak5);
                end
`ifdef COLLATZ_STATS_ODD_EN
                n_tests++;
                if (odd5 !== 4'd15) begin
                    n_fail++;
                    $display("FAIL wdog_odd_sat got=%0d want=15", odd5);
                end
`endif
            end
        end
        bs5 = 1'b0; rdy5 = 1'b0;
        n_tests++;
        if (first != 51) begin
            n_fail++;
            $display("FAIL wdog_latency got=%0d want=51", first);
        end
        n_tests++;
        if (late != 0 || ovr5 !== 1'b0 || start5 !== 16'd1) begin
            n_fail++;
            $display("FAIL wdog_tail_ignored got=%0d/%b/%0d want=0/0/1", late, ovr5, start5);
        end
    endtask

    task automatic test_reset_mid_run;
        bs = 1'b1; x = 16'd9;
        @(negedge clk);
        x = 16'd28;
        @(negedge clk);
        x = 16'd14;
        @(negedge clk);
        n_tests++;
        if ({start_v, peak_v, steps} !== {16'd9, 16'd28, 10'd2}) begin
            n_fail++;
            $display("FAIL midrun_progress got=%0d/%0d/%0d want=9/28/2", start_v, peak_v, steps);
        end
        rst_n = 1'b0; bs = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({vld, start_v, peak_v, steps, sat, tmo, ovr} !== 47'd0) begin
            n_fail++;
            $display("FAIL midrun_reset got=%h want=0", {vld, start_v, peak_v, steps, sat, tmo, ovr});
        end
        rst_n = 1'b1;
        @(negedge clk);
        orbit_q = '{16'd3, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
        play(1);
        bs = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({vld, start_v, peak_v, steps, sat, tmo, ovr} !== {1'b1, 16'd3, 16'd16, 10'd7, 3'b000}) begin
            n_fail++;
            $display("FAIL after_reset_record got=%b/%0d/%0d/%0d/%b%b%b want=1/3/16/7/000",
                     vld, start_v, peak_v, steps, sat, tmo, ovr);
        end
`ifdef COLLATZ_STATS_ODD_EN
        n_tests++;
        if (odd_cnt !== 10'd3) begin
            n_fail++;
            $display("FAIL after_reset_odd got=%0d want=3", odd_cnt);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_held;
        test_accept_on_rise;
        test_watchdog;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1);
    end

endmodule
